// File: rtl/bmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bmem_arbiter_pkg
//   Shared definitions for the burst-memory request path: bus widths, the
//   default read burst length and the arbiter state encoding. The memory
//   controller imports the same package so both sides agree on widths and
//   burst length.
// -----------------------------------------------------------------------------
package bmem_arbiter_pkg;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 64;
    localparam int RD_BEATS_DEF = 4;
    localparam int BEAT_CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_BUSY    = 2'd1,
        WR_BUSY    = 2'd2,
        WR_RELEASE = 2'd3
    } bmem_state_e;

endpackage

// File: rtl/bmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// bmem_arbiter_if
//   One burst-memory request/response channel.
//   Request  (master -> slave): addr, read, write, wdata
//   Response (slave -> master): ready, raddr, rdata, rvalid, wburst_counter
//   A requester port uses the master modport; the arbiter sees each requester
//   through the slave modport and drives the memory controller through the
//   master modport.
// -----------------------------------------------------------------------------
interface bmem_arbiter_if;
    import bmem_arbiter_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] wdata;

    logic              ready;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              wburst_counter;

    modport master (
        output addr, read, write, wdata,
        input  ready, raddr, rdata, rvalid, wburst_counter
    );

    modport slave (
        input  addr, read, write, wdata,
        output ready, raddr, rdata, rvalid, wburst_counter
    );

endinterface

// File: rtl/bmem_arbiter.sv
// -----------------------------------------------------------------------------
// bmem_arbiter
//   Two-requester round-robin arbiter in front of one burst memory controller.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     p0, p1   : requester channels (slave side)
//     m        : memory controller channel (master side)
//   Parameter:
//     RD_BEATS : rvalid pulses that make up one read burst
//   In IDLE the winner's request is passed straight through so the controller
//   can latch it the same cycle; once accepted the grant is held until the read
//   burst completes or the write is acknowledged and the requester releases it.
// -----------------------------------------------------------------------------
module bmem_arbiter
    import bmem_arbiter_pkg::*;
#(
    parameter int RD_BEATS = RD_BEATS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    bmem_arbiter_if.slave  p0,
    bmem_arbiter_if.slave  p1,
    bmem_arbiter_if.master m
);

    bmem_state_e           state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic                  req0, req1, any_req;
    logic                  winner, sel, accept;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_read, sel_write;

    // Round-robin pick and request selection
    always_comb begin
        req0    = p0.read | p0.write;
        req1    = p1.read | p1.write;
        any_req = req0 | req1;
        // On a tie the port that did not win last time goes; otherwise the lone
        // requester (or port 0 when nobody asks, which is never used).
        if (req0 && req1) winner = ~last_grant_q;
        else              winner = req1;
        sel       = (state_q == IDLE) ? winner : grant_q;
        sel_addr  = sel ? p1.addr  : p0.addr;
        sel_wdata = sel ? p1.wdata : p0.wdata;
        sel_read  = sel ? p1.read  : p0.read;
        sel_write = sel ? p1.write : p0.write;
        accept    = (state_q == IDLE) && any_req && m.ready;
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    beat_cnt_d   = '0;
                    // read+write together is a write
                    state_d      = sel_write ? WR_BUSY : RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (m.rvalid) begin
                    if (beat_cnt_q == BEAT_CNT_W'(RD_BEATS - 1)) state_d = IDLE;
                    // saturate rather than wrap
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            WR_BUSY: begin
                if (m.ready) state_d = WR_RELEASE;
            end
            WR_RELEASE: begin
                if (!sel_write) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Output logic; everything is forced low while rst is held
    always_comb begin
        m.addr            = '0;
        m.read            = 1'b0;
        m.write           = 1'b0;
        m.wdata           = '0;
        p0.ready          = 1'b0;
        p0.raddr          = '0;
        p0.rdata          = '0;
        p0.rvalid         = 1'b0;
        p0.wburst_counter = 1'b0;
        p1.ready          = 1'b0;
        p1.raddr          = '0;
        p1.rdata          = '0;
        p1.rvalid         = 1'b0;
        p1.wburst_counter = 1'b0;
        if (!rst) begin
            if (state_q != IDLE || any_req) begin
                m.addr  = sel_addr;
                m.wdata = sel_wdata;
                m.write = sel_write;
                m.read  = sel_read & ~sel_write;
            end
            if (state_q == IDLE) begin
                // Only ready reaches the winner; stray rvalid is dropped here.
                if (any_req) begin
                    if (winner) p1.ready = m.ready;
                    else        p0.ready = m.ready;
                end
            end else if (grant_q) begin
                p1.ready          = m.ready;
                p1.raddr          = m.raddr;
                p1.rdata          = m.rdata;
                p1.rvalid         = m.rvalid;
                p1.wburst_counter = m.wburst_counter;
            end else begin
                p0.ready          = m.ready;
                p0.raddr          = m.raddr;
                p0.rdata          = m.rdata;
                p0.rvalid         = m.rvalid;
                p0.wburst_counter = m.wburst_counter;
            end
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bmem_arbiter
//   Self-checking bench for bmem_arbiter. A transaction-level model (who owns
//   the controller, what kind of transfer, how many beats seen) predicts every
//   output each cycle; scenario tasks add directed checks on top.
// -----------------------------------------------------------------------------
module tb_bmem_arbiter;
    import bmem_arbiter_pkg::*;

    localparam int RD_BEATS = 4;
    localparam int PW       = 1 + ADDR_W + DATA_W + 2;
    localparam int OBS_W    = ADDR_W + 2 + DATA_W + 2 * PW;
    typedef logic [OBS_W-1:0] obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bmem_arbiter_if p0_if ();
    bmem_arbiter_if p1_if ();
    bmem_arbiter_if m_if ();

    bmem_arbiter #(.RD_BEATS(RD_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if),
        .p1  (p1_if),
        .m   (m_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Transaction model: free, or owned by one port doing a read (counting
    // beats) or a write (waiting for ack, then for the port to let go).
    bit mdl_busy  = 0;
    int mdl_owner = 0;
    bit mdl_is_wr = 0;
    bit mdl_acked = 0;
    int mdl_beats = 0;
    int mdl_last  = 1;

    function automatic obs_t dut_obs();
        return {m_if.addr, m_if.read, m_if.write, m_if.wdata,
                p0_if.ready, p0_if.raddr, p0_if.rdata, p0_if.rvalid, p0_if.wburst_counter,
                p1_if.ready, p1_if.raddr, p1_if.rdata, p1_if.rvalid, p1_if.wburst_counter};
    endfunction

    function automatic int pick();
        bit rq0 = p0_if.read || p0_if.write;
        bit rq1 = p1_if.read || p1_if.write;
        if (mdl_busy)    return mdl_owner;
        if (rq0 && rq1)  return 1 - mdl_last;
        return rq0 ? 0 : 1;
    endfunction

    function automatic obs_t model_exp();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic rd, wr;
        logic [PW-1:0] resp, r0, r1;
        int who;
        if (rst) return '0;
        if (!mdl_busy && !(p0_if.read || p0_if.write || p1_if.read || p1_if.write)) return '0;
        who = pick();
        a  = (who == 1) ? p1_if.addr  : p0_if.addr;
        d  = (who == 1) ? p1_if.wdata : p0_if.wdata;
        rd = (who == 1) ? p1_if.read  : p0_if.read;
        wr = (who == 1) ? p1_if.write : p0_if.write;
        if (mdl_busy) resp = {m_if.ready, m_if.raddr, m_if.rdata, m_if.rvalid, m_if.wburst_counter};
        else          resp = {m_if.ready, {(PW-1){1'b0}}};
        r0 = (who == 0) ? resp : '0;
        r1 = (who == 1) ? resp : '0;
        return {a, rd & ~wr, wr, d, r0, r1};
    endfunction

    task automatic model_commit();
        int who;
        if (rst) begin
            mdl_busy = 0; mdl_last = 1; mdl_beats = 0;
            return;
        end
        who = pick();
        if (!mdl_busy) begin
            if ((p0_if.read || p0_if.write || p1_if.read || p1_if.write) && m_if.ready) begin
                mdl_busy  = 1;
                mdl_owner = who;
                mdl_last  = who;
                mdl_is_wr = (who == 1) ? p1_if.write : p0_if.write;
                mdl_acked = 0;
                mdl_beats = 0;
            end
        end else if (!mdl_is_wr) begin
            if (m_if.rvalid) begin
                mdl_beats++;
                if (mdl_beats == RD_BEATS) mdl_busy = 0;
            end
        end else if (!mdl_acked) begin
            if (m_if.ready) mdl_acked = 1;
        end else if (!((mdl_owner == 1) ? p1_if.write : p0_if.write)) begin
            mdl_busy = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_p(input int n, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (n == 0) begin
            p0_if.read = rd; p0_if.write = wr; p0_if.addr = a; p0_if.wdata = d;
        end else begin
            p1_if.read = rd; p1_if.write = wr; p1_if.addr = a; p1_if.wdata = d;
        end
    endtask

    task automatic set_m(input logic rdy, input logic rv, input logic wb);
        m_if.ready          = rdy;
        m_if.rvalid         = rv;
        m_if.wburst_counter = wb;
        m_if.raddr          = $urandom;
        m_if.rdata          = {$urandom, $urandom};
    endtask

    task automatic rand_inputs();
        set_p(0, ($urandom % 2) == 0, ($urandom % 4) == 0, $urandom, {$urandom, $urandom});
        set_p(1, ($urandom % 2) == 0, ($urandom % 4) == 0, $urandom, {$urandom, $urandom});
        set_m(($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 2) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_p(0, 0, 0, '0, '0);
        set_p(1, 0, 0, '0, '0);
        set_m(0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            @(negedge clk);
            checks++;
            if (dut_obs() !== '0) $display("FAIL reset_zero cyc %0d: got %h want 0", i, dut_obs());
            else passed++;
            tick();
        end
        rst = 1'b0;
        set_p(0, 1, 0, 32'h0000_0010, '0);
        set_p(1, 1, 0, 32'h0000_0020, '0);
        set_m(1, 0, 0);
        @(negedge clk);
        checks++;
        if ({p0_if.ready, p1_if.ready} !== 2'b10)
            $display("FAIL reset_first_tie: got %b want 10", {p0_if.ready, p1_if.ready});
        else passed++;
        checks++;
        if (dut_obs() !== model_exp()) $display("FAIL reset_model: got %h want %h", dut_obs(), model_exp());
        else passed++;
        tick();
    endtask

    task automatic test_single_read();
        logic [8:0] rv_pat = 9'b110010110;
        int p0_beats = 0;
        do_reset();
        set_p(0, 1, 0, 32'h0000_1000, '0);
        set_m(1, 0, 0);
        @(negedge clk);
        checks++;
        if (m_if.addr !== 32'h0000_1000 || m_if.read !== 1'b1 || p0_if.ready !== 1'b1)
            $display("FAIL single_read_accept: got addr=%h rd=%b rdy=%b want 00001000 1 1",
                     m_if.addr, m_if.read, p0_if.ready);
        else passed++;
        tick();
        set_p(0, 0, 0, '0, '0);
        set_p(1, 1, 0, 32'h0000_2000, '0);
        for (int i = 0; i < 9; i++) begin
            set_m(1, rv_pat[i], 0);
            @(negedge clk);
            checks++;
            if (dut_obs() !== model_exp()) $display("FAIL single_read_model cyc %0d: got %h want %h", i, dut_obs(), model_exp());
            else passed++;
            p0_beats += p0_if.rvalid;
            if (i == 7) begin
                checks++;
                if (p1_if.ready !== 1'b0) $display("FAIL single_read_turnaround: got p1_ready=%b want 0", p1_if.ready);
                else passed++;
            end
            if (i == 8) begin
                checks++;
                if (p1_if.ready !== 1'b1 || p0_if.rvalid !== 1'b0 || p1_if.rvalid !== 1'b0)
                    $display("FAIL single_read_idle: got rdy1=%b rv0=%b rv1=%b want 1 0 0",
                             p1_if.ready, p0_if.rvalid, p1_if.rvalid);
                else passed++;
            end
            tick();
        end
        checks++;
        if (p0_beats != RD_BEATS) $display("FAIL single_read_beats: got %0d want %0d", p0_beats, RD_BEATS);
        else passed++;
    endtask

    task automatic test_round_robin();
        int acc[$];
        do_reset();
        set_p(0, 1, 0, 32'h0000_0100, '0);
        set_p(1, 1, 0, 32'h0000_0200, '0);
        for (int i = 0; i < 200 && acc.size() < 4; i++) begin
            set_m(1, ($urandom % 2) == 0, 0);
            @(negedge clk);
            checks++;
            if (dut_obs() !== model_exp()) $display("FAIL rr_model cyc %0d: got %h want %h", i, dut_obs(), model_exp());
            else passed++;
            if (!mdl_busy && m_if.ready) begin
                if (p0_if.ready)      acc.push_back(0);
                else if (p1_if.ready) acc.push_back(1);
                checks++;
                if (m_if.addr !== ((acc.size() % 2 == 1) ? 32'h0000_0100 : 32'h0000_0200))
                    $display("FAIL rr_addr: got %h at grant %0d", m_if.addr, acc.size());
                else passed++;
            end
            tick();
        end
        checks++;
        if (acc.size() != 4) $display("FAIL rr_timeout: got %0d grants want 4", acc.size());
        else passed++;
        foreach (acc[k]) begin
            checks++;
            if (acc[k] != k % 2) $display("FAIL rr_order grant %0d: got p%0d want p%0d", k, acc[k], k % 2);
            else passed++;
        end
    endtask

    task automatic test_write();
        do_reset();
        set_p(1, 0, 1, 32'h0000_0300, 64'hDEAD_BEEF_CAFE_F00D);
        set_m(1, 0, 0);
        @(negedge clk);
        checks++;
        if (m_if.write !== 1'b1 || m_if.read !== 1'b0 || m_if.addr !== 32'h0000_0300 ||
            m_if.wdata !== 64'hDEAD_BEEF_CAFE_F00D || p1_if.ready !== 1'b1)
            $display("FAIL write_accept: got wr=%b rd=%b addr=%h data=%h rdy=%b",
                     m_if.write, m_if.read, m_if.addr, m_if.wdata, p1_if.ready);
        else passed++;
        tick();
        set_p(0, 1, 0, 32'h0000_0400, '0);
        for (int i = 0; i < 8; i++) begin
            set_m(0, 0, logic'(i % 2));
            @(negedge clk);
            checks++;
            if (p1_if.wburst_counter !== logic'(i % 2) || p0_if.wburst_counter !== 1'b0 || p0_if.ready !== 1'b0)
                $display("FAIL write_burst cyc %0d: got wb1=%b wb0=%b rdy0=%b want %0d 0 0",
                         i, p1_if.wburst_counter, p0_if.wburst_counter, p0_if.ready, i % 2);
            else passed++;
            checks++;
            if (dut_obs() !== model_exp()) $display("FAIL write_model cyc %0d: got %h want %h", i, dut_obs(), model_exp());
            else passed++;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) set_p(1, 0, 0, '0, '0);
            set_m(1, 0, 0);
            @(negedge clk);
            checks++;
            if (p0_if.ready !== 1'b0 || p1_if.ready !== 1'b1)
                $display("FAIL write_hold cyc %0d: got rdy0=%b rdy1=%b want 0 1", i, p0_if.ready, p1_if.ready);
            else passed++;
            tick();
        end
        @(negedge clk);
        checks++;
        if (p0_if.ready !== 1'b1 || m_if.addr !== 32'h0000_0400)
            $display("FAIL write_release: got rdy0=%b addr=%h want 1 00000400", p0_if.ready, m_if.addr);
        else passed++;
        tick();
    endtask

    task automatic test_rw_same_port();
        do_reset();
        set_p(0, 1, 1, 32'h0000_0500, 64'h1234_5678_9ABC_DEF0);
        set_m(1, 0, 0);
        @(negedge clk);
        checks++;
        if (m_if.write !== 1'b1 || m_if.read !== 1'b0)
            $display("FAIL rw_accept: got wr=%b rd=%b want 1 0", m_if.write, m_if.read);
        else passed++;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_p(0, 0, 0, '0, '0);
            set_m(1, 1, 0);
            @(negedge clk);
            checks++;
            if (dut_obs() !== model_exp()) $display("FAIL rw_model cyc %0d: got %h want %h", i, dut_obs(), model_exp());
            else passed++;
            tick();
        end
    endtask

    task automatic test_reset_midburst();
        int p1_beats = 0;
        do_reset();
        set_p(0, 1, 0, 32'h0000_0600, '0);
        set_m(1, 0, 0);
        tick();
        set_p(0, 0, 0, '0, '0);
        set_m(0, 1, 0);
        tick();
        tick();
        rst = 1'b1;
        set_p(0, 1, 0, 32'h0000_0600, '0);
        set_m(1, 1, 1);
        @(negedge clk);
        checks++;
        if (dut_obs() !== '0) $display("FAIL midburst_zero: got %h want 0", dut_obs());
        else passed++;
        tick();
        rst = 1'b0;
        set_p(0, 0, 0, '0, '0);
        set_p(1, 1, 0, 32'h0000_0700, '0);
        set_m(1, 1, 0);
        @(negedge clk);
        checks++;
        if (p1_if.ready !== 1'b1 || m_if.addr !== 32'h0000_0700 || p1_if.rvalid !== 1'b0)
            $display("FAIL midburst_idle: got rdy1=%b addr=%h rv1=%b want 1 00000700 0",
                     p1_if.ready, m_if.addr, p1_if.rvalid);
        else passed++;
        tick();
        set_p(1, 0, 0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            set_m(0, 1, 0);
            @(negedge clk);
            checks++;
            if (dut_obs() !== model_exp()) $display("FAIL midburst_model cyc %0d: got %h want %h", i, dut_obs(), model_exp());
            else passed++;
            p1_beats += p1_if.rvalid;
            tick();
        end
        checks++;
        if (p1_beats != RD_BEATS) $display("FAIL midburst_beats: got %0d want %0d", p1_beats, RD_BEATS);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            rst = (($urandom % 60) == 0);
            @(negedge clk);
            checks++;
            if (dut_obs() !== model_exp()) $display("FAIL random_model cyc %0d: got %h want %h", i, dut_obs(), model_exp());
            else passed++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        set_p(0, 0, 0, '0, '0);
        set_p(1, 0, 0, '0, '0);
        set_m(0, 0, 0);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_rw_same_port();
        test_reset_midburst();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
